mp_regfile: RTL and testbench
=============================

// Module: mp_regfile
// PURPOSE
//  Parametrised multi-port register file with write-through bypass and a per-register
//  pending scoreboard. Replaces the fixed 2R/1W 32x32 file in the pipelined core.
//  Read in D stage, written by W stage (two write ports for dual-issue/late results).
//  Busy bits let hazard logic stall on registers with an outstanding producer.
// PARAMETERS
//  DW  32  data width in bits
//  AW  5   address width; depth = 2**AW registers
//  NR  2   number of read ports (1..4)
// PORTS
//  clk     in   1      clock, all state updates on rising edge
//  reset   in   1      synchronous, active-high
//  raddr   in   NR*AW  read addresses, port i at [i*AW +: AW]
//  rdata   out  NR*DW  read data, port i at [i*DW +: DW]
//  rbusy   out  NR     1 = register read by port i has a pending producer
//  we0     in   1      write enable, port 0
//  wa0     in   AW     write address, port 0
//  wd0     in   DW     write data, port 0
//  wpc0    in   32     PC of instruction writing on port 0 (trace only)
//  we1     in   1      write enable, port 1
//  wa1     in   AW     write address, port 1
//  wd1     in   DW     write data, port 1
//  wpc1    in   32     PC of instruction writing on port 1 (trace only)
//  set_en  in   1      mark register set_addr pending (issue of a producer)
//  set_addr in  AW     register to mark pending
//  busy    out  2**AW  full scoreboard vector, bit r = register r pending
// BEHAVIOUR
//  - Reset (sync): all registers <= 0, all busy bits <= 0. Reset overrides writes/sets
//    in the same cycle. Post-reset: every rdata = 0, rbusy = 0, busy = 0.
//  - Register 0 is hardwired zero: writes to address 0 are dropped, reads of 0 return 0
//    and are never bypassed, busy[0] is never set (always 0).
//  - Write: on posedge with weN=1 and waN!=0, reg[waN] <= wdN. 1-cycle write latency.
//  - Both ports same nonzero address same cycle: port 1 wins (port 0 data discarded).
//  - Read: combinational, 0-cycle. Write-through bypass: if raddr_i matches an active
//    nonzero write address this cycle, rdata_i = that write data (port 1 over port 0),
//    else stored value.
//  - Scoreboard: any accepted write to r clears busy[r] next edge. set_en with
//    set_addr!=0 sets busy[set_addr] next edge. Set and clear on same r same cycle:
//    set wins (newer producer issued). set_addr=0 ignored.
//  - rbusy_i = busy[raddr_i] & ~(bypass hit on raddr_i this cycle); raddr_i=0 -> 0.
//  - Reads of unrelated ports independent; all NR ports may address same register.
// CONFIGURATION
//  RF_TRACE_EN defined: on each accepted write edge (weN=1, not in reset) print
//    "%d@%h: $%d <= %h" (time, wpcN, waN, wdN); port 0 line first. Printed even
//    when waN=0 (write still dropped); when both ports hit same address both print.
//  RF_TRACE_EN undefined: no $display; wpc0/wpc1 unused; datapath identical.
// TESTING
//  1 reset, read all regs on every port -> rdata=0, rbusy=0, busy=0.
//  2 we0=1 wa0=5 wd0=32'hDEADBEEF, raddr0=5 same cycle -> rdata0=DEADBEEF (bypass);
//    next cycle we0=0 -> rdata0 still DEADBEEF from storage.
//  3 we0=1 wa0=0 wd0=32'h1234 -> rdata for raddr=0 stays 0 same and next cycle.
//  4 we0/we1 both wa=7, wd0=1, wd1=2 -> rdata(7)=2 same cycle and after edge.
//  5 set_en addr=9 -> busy[9]=1, rbusy=1 on port reading 9; then we1 wa1=9 wd1=3:
//    rbusy=0 that cycle, busy[9]=0 after edge; set_en+we0 both addr 9 -> busy[9]=1.
//  6 load regs then assert reset mid-stream with we0=1 wa0=4 -> all regs 0, busy 0,
//    reg4=0; with RF_TRACE_EN, no trace line for that cycle.

Source files
------------

// File: rtl/mp_regfile_if.sv
// Register-file port bundle: read ports, two write ports, scoreboard set and busy vector.
interface mp_regfile_if #(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 5,
  parameter int unsigned NR = 2
);
  logic [NR*AW-1:0] raddr;
  logic [NR*DW-1:0] rdata;
  logic [NR-1:0]    rbusy;
  logic             we0;
  logic [AW-1:0]    wa0;
  logic [DW-1:0]    wd0;
  logic [31:0]      wpc0;
  logic             we1;
  logic [AW-1:0]    wa1;
  logic [DW-1:0]    wd1;
  logic [31:0]      wpc1;
  logic             set_en;
  logic [AW-1:0]    set_addr;
  logic [2**AW-1:0] busy;

  modport master (
    output raddr, we0, wa0, wd0, wpc0, we1, wa1, wd1, wpc1, set_en, set_addr,
    input  rdata, rbusy, busy
  );

  modport slave (
    input  raddr, we0, wa0, wd0, wpc0, we1, wa1, wd1, wpc1, set_en, set_addr,
    output rdata, rbusy, busy
  );
endinterface

// File: rtl/mp_regfile.sv
// Multi-port register file with write-through bypass and per-register pending scoreboard.
// Define RF_TRACE_EN to print a trace line for every accepted write.
module mp_regfile #(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 5,
  parameter int unsigned NR = 2
) (
  input logic         clk,
  input logic         reset,
  mp_regfile_if.slave bus_io
);
  localparam int unsigned Depth = 2**AW;

  logic [DW-1:0]    regs_q [Depth];
  logic [DW-1:0]    regs_d [Depth];
  logic [Depth-1:0] busy_q, busy_d;
  logic             wr0, wr1;
  logic [AW-1:0]    ra;
  logic             hit0, hit1;

  // Address 0 is hardwired zero, so it never counts as an accepted write.
  assign wr0 = bus_io.we0 && (bus_io.wa0 != '0);
  assign wr1 = bus_io.we1 && (bus_io.wa1 != '0);

  always_comb begin
    regs_d = regs_q;
    if (wr0) regs_d[bus_io.wa0] = bus_io.wd0;
    if (wr1) regs_d[bus_io.wa1] = bus_io.wd1;
    regs_d[0] = '0;
  end

  // Set is applied after clears so a newly issued producer wins over a retiring one.
  always_comb begin
    busy_d = busy_q;
    if (wr0) busy_d[bus_io.wa0] = 1'b0;
    if (wr1) busy_d[bus_io.wa1] = 1'b0;
    if (bus_io.set_en && (bus_io.set_addr != '0)) busy_d[bus_io.set_addr] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      regs_q <= '{default: '0};
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

  always_comb begin
    bus_io.rdata = '0;
    bus_io.rbusy = '0;
    ra           = '0;
    hit0         = 1'b0;
    hit1         = 1'b0;
    for (int i = 0; i < int'(NR); i++) begin
      ra   = bus_io.raddr[i*AW +: AW];
      hit0 = wr0 && (bus_io.wa0 == ra);
      hit1 = wr1 && (bus_io.wa1 == ra);
      if (hit1) begin
        bus_io.rdata[i*DW +: DW] = bus_io.wd1;
      end else if (hit0) begin
        bus_io.rdata[i*DW +: DW] = bus_io.wd0;
      end else begin
        bus_io.rdata[i*DW +: DW] = regs_q[ra];
      end
      bus_io.rbusy[i] = busy_q[ra] & ~(hit0 | hit1);
    end
  end

  assign bus_io.busy = busy_q;

`ifdef RF_TRACE_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (bus_io.we0) $display("%d@%h: $%d <= %h", $time, bus_io.wpc0, bus_io.wa0, bus_io.wd0);
      if (bus_io.we1) $display("%d@%h: $%d <= %h", $time, bus_io.wpc1, bus_io.wa1, bus_io.wd1);
    end
  end
`else
  logic unused_wpc;
  assign unused_wpc = ^{bus_io.wpc0, bus_io.wpc1};
`endif
endmodule

// File: tb/tb_mp_regfile.sv
// Directed self-checking bench for mp_regfile (DW=32, AW=5, NR=2).
module tb_mp_regfile;
  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  mp_regfile_if #(.DW(32), .AW(5), .NR(2)) rf_if ();

  mp_regfile #(.DW(32), .AW(5), .NR(2)) dut (
    .clk    (clk),
    .reset  (reset),
    .bus_io (rf_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rf_if.we0      = 1'b0;
    rf_if.we1      = 1'b0;
    rf_if.set_en   = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a0, input logic [4:0] a1);
    rf_if.raddr = {a1, a0};
    #1;
  endtask

  function automatic logic [31:0] rdata(input int p);
    return rf_if.rdata[p*32 +: 32];
  endfunction

  initial begin
    n_checks       = 0;
    n_errors       = 0;
    reset          = 1'b1;
    rf_if.raddr    = '0;
    rf_if.wa0      = '0;
    rf_if.wd0      = '0;
    rf_if.wpc0     = 32'h0000_1000;
    rf_if.wa1      = '0;
    rf_if.wd1      = '0;
    rf_if.wpc1     = 32'h0000_1004;
    rf_if.set_addr = '0;
    idle();
    tick();
    tick();
    reset = 1'b0;

    // 1: everything reads zero after reset
    check_eq("reset_busy", 64'(rf_if.busy), 64'h0);
    for (int r = 0; r < 32; r++) begin
      rd(5'(r), 5'(31 - r));
      check_eq($sformatf("reset_rd0_r%0d", r), 64'(rdata(0)), 64'h0);
      check_eq($sformatf("reset_rd1_r%0d", 31 - r), 64'(rdata(1)), 64'h0);
      check_eq($sformatf("reset_rbusy_r%0d", r), 64'(rf_if.rbusy), 64'h0);
    end

    // 2: bypass on write cycle, then storage
    rf_if.we0 = 1'b1; rf_if.wa0 = 5'd5; rf_if.wd0 = 32'hDEADBEEF;
    rd(5'd5, 5'd6);
    check_eq("bypass_r5", 64'(rdata(0)), 64'hDEADBEEF);
    check_eq("bypass_other_r6", 64'(rdata(1)), 64'h0);
    tick();
    idle();
    rd(5'd5, 5'd5);
    check_eq("stored_r5_p0", 64'(rdata(0)), 64'hDEADBEEF);
    check_eq("stored_r5_p1", 64'(rdata(1)), 64'hDEADBEEF);

    // 3: writes to register 0 are dropped and never bypassed
    rf_if.we0 = 1'b1; rf_if.wa0 = 5'd0; rf_if.wd0 = 32'h1234;
    rd(5'd0, 5'd0);
    check_eq("r0_same_cycle", 64'(rdata(0)), 64'h0);
    tick();
    idle();
    rd(5'd0, 5'd0);
    check_eq("r0_next_cycle", 64'(rdata(1)), 64'h0);

    // 4: both ports write the same register, port 1 wins
    rf_if.we0 = 1'b1; rf_if.wa0 = 5'd7; rf_if.wd0 = 32'd1;
    rf_if.we1 = 1'b1; rf_if.wa1 = 5'd7; rf_if.wd1 = 32'd2;
    rd(5'd7, 5'd7);
    check_eq("dual_wr_bypass_p0", 64'(rdata(0)), 64'd2);
    check_eq("dual_wr_bypass_p1", 64'(rdata(1)), 64'd2);
    tick();
    idle();
    rd(5'd7, 5'd5);
    check_eq("dual_wr_stored", 64'(rdata(0)), 64'd2);
    check_eq("indep_port_r5", 64'(rdata(1)), 64'hDEADBEEF);

    // Different addresses on both write ports in one cycle
    rf_if.we0 = 1'b1; rf_if.wa0 = 5'd10; rf_if.wd0 = 32'hA0A0;
    rf_if.we1 = 1'b1; rf_if.wa1 = 5'd11; rf_if.wd1 = 32'hB1B1;
    rd(5'd10, 5'd11);
    check_eq("split_bypass_p0", 64'(rdata(0)), 64'hA0A0);
    check_eq("split_bypass_p1", 64'(rdata(1)), 64'hB1B1);
    tick();
    idle();
    rd(5'd11, 5'd10);
    check_eq("split_stored_r11", 64'(rdata(0)), 64'hB1B1);
    check_eq("split_stored_r10", 64'(rdata(1)), 64'hA0A0);

    // 5: scoreboard set, clear with bypass, set-wins collision, set of 0 ignored
    rf_if.set_en = 1'b1; rf_if.set_addr = 5'd9;
    rd(5'd0, 5'd9);
    check_eq("busy_before_edge", 64'(rf_if.busy), 64'h0);
    tick();
    idle();
    rd(5'd0, 5'd9);
    check_eq("busy9_set", 64'(rf_if.busy), 64'h200);
    check_eq("rbusy_r9", 64'(rf_if.rbusy), 64'b10);
    rf_if.we1 = 1'b1; rf_if.wa1 = 5'd9; rf_if.wd1 = 32'd3;
    rd(5'd9, 5'd9);
    check_eq("rbusy_bypass_hit", 64'(rf_if.rbusy), 64'b00);
    check_eq("rdata_bypass_r9", 64'(rdata(1)), 64'd3);
    check_eq("busy9_still_set", 64'(rf_if.busy), 64'h200);
    tick();
    idle();
    rd(5'd9, 5'd9);
    check_eq("busy9_cleared", 64'(rf_if.busy), 64'h0);
    check_eq("rbusy_after_clear", 64'(rf_if.rbusy), 64'b00);
    rf_if.set_en = 1'b1; rf_if.set_addr = 5'd9;
    rf_if.we0 = 1'b1; rf_if.wa0 = 5'd9; rf_if.wd0 = 32'd4;
    tick();
    idle();
    rd(5'd9, 5'd9);
    check_eq("set_wins_busy", 64'(rf_if.busy), 64'h200);
    check_eq("set_wins_rbusy", 64'(rf_if.rbusy), 64'b11);
    check_eq("set_wins_data", 64'(rdata(0)), 64'd4);
    rf_if.set_en = 1'b1; rf_if.set_addr = 5'd0;
    tick();
    idle();
    rd(5'd0, 5'd9);
    check_eq("set0_ignored", 64'(rf_if.busy), 64'h200);
    check_eq("rbusy_r0_zero", 64'(rf_if.rbusy), 64'b10);

    // 6: reset mid-stream overrides a write and a set
    rf_if.we0 = 1'b1; rf_if.wa0 = 5'd4; rf_if.wd0 = 32'hAA;
    tick();
    idle();
    rd(5'd4, 5'd4);
    check_eq("pre_reset_r4", 64'(rdata(0)), 64'hAA);
    reset = 1'b1;
    rf_if.we0 = 1'b1; rf_if.wa0 = 5'd4; rf_if.wd0 = 32'h55;
    rf_if.set_en = 1'b1; rf_if.set_addr = 5'd12;
    tick();
    reset = 1'b0;
    idle();
    rd(5'd4, 5'd5);
    check_eq("post_reset_r4", 64'(rdata(0)), 64'h0);
    check_eq("post_reset_r5", 64'(rdata(1)), 64'h0);
    check_eq("post_reset_busy", 64'(rf_if.busy), 64'h0);
    rd(5'd7, 5'd9);
    check_eq("post_reset_r7", 64'(rdata(0)), 64'h0);
    check_eq("post_reset_r9", 64'(rdata(1)), 64'h0);
    check_eq("post_reset_rbusy", 64'(rf_if.rbusy), 64'b00);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
